// File: rtl/regfile_pkg.sv
// Shared constants, scrub FSM state type and parity helper for the multi-port register file.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 32;
   localparam int PAR_W      = 128;

   typedef enum logic {ST_IDLE, ST_CLEAR} scrub_st_t;

   // Even parity over a zero-extended word; callers cast their data to PAR_W.
   function automatic logic parity(input logic [PAR_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/regfile_scrub_ctrl.sv
// Scrub sequencer: walks every entry once, writing zero, after reset or a clear request.
module regfile_scrub_ctrl
   import regfile_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              busy,
   output logic              scrub_we,
   output logic [ADDR_W-1:0] scrub_addr
);

   scrub_st_t         state, state_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: begin
            if (clr_req) begin
               state_nx = ST_CLEAR;
               cnt_nx   = '0;
            end
         end
         ST_CLEAR: begin
            // A request arriving here is ignored, so the walk never restarts.
            if (cnt == ADDR_W'(DEPTH - 1)) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign busy       = (state == ST_CLEAR);
   assign scrub_we   = busy;
   assign scrub_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write bypass, conflict flag and scrub.
// Optional per-entry parity checking is enabled with REGFILE_PARITY_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_req,
   output logic                     busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic                     wr_conflict,
   output logic                     par_err,
   output logic [ADDR_W-1:0]        par_err_addr
);

   logic              scrub_we;
   logic [ADDR_W-1:0] scrub_addr;

   regfile_scrub_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_scrub (
      .clk        (clk),
      .rst        (rst),
      .clr_req    (clr_req),
      .busy       (busy),
      .scrub_we   (scrub_we),
      .scrub_addr (scrub_addr)
   );

   logic [DATA_W-1:0] mem [DEPTH];
`ifdef REGFILE_PARITY_EN
   logic              par_mem [DEPTH];
`endif

   logic [NUM_WR-1:0] wr_live;   // enabled and not blocked by a scrub
   logic [NUM_WR-1:0] wr_act;    // actually lands in the array
   logic              conflict_nx;

   always_comb begin
      wr_live     = '0;
      wr_act      = '0;
      conflict_nx = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
         wr_live[k] = wr_en[k] & ~busy;
         wr_act[k]  = wr_live[k] &
                      ~((ZERO_REG != 0) && (wr_addr[k*ADDR_W +: ADDR_W] == '0));
      end
      for (int i = 0; i < NUM_WR; i++)
         for (int j = i + 1; j < NUM_WR; j++)
            if (wr_live[i] && wr_live[j] &&
                wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])
               conflict_nx = 1'b1;
   end

   // Ascending port order makes the highest-index writer win on a shared address.
   always_ff @(posedge clk) begin
      if (scrub_we) begin
         mem[scrub_addr] <= '0;
`ifdef REGFILE_PARITY_EN
         par_mem[scrub_addr] <= 1'b0;
`endif
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_act[k]) begin
               mem[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
`ifdef REGFILE_PARITY_EN
               par_mem[wr_addr[k*ADDR_W +: ADDR_W]] <=
                  parity(PAR_W'(wr_data[k*DATA_W +: DATA_W]));
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) wr_conflict <= 1'b0;
      else     wr_conflict <= conflict_nx;
   end

`ifdef REGFILE_PARITY_EN
   logic [NUM_RD-1:0] perr_p;
`endif

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              byp;
      logic              zr;

      assign a  = rd_addr[p*ADDR_W +: ADDR_W];
      assign zr = (ZERO_REG != 0) && (a == '0);

      always_comb begin
         d   = mem[a];
         byp = 1'b0;
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == a) begin
               d   = wr_data[k*DATA_W +: DATA_W];
               byp = 1'b1;
            end
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = (busy || zr) ? '0 : d;

`ifdef REGFILE_PARITY_EN
      assign perr_p[p] = !busy && !zr && !byp &&
                         (parity(PAR_W'(mem[a])) != par_mem[a]);
`endif
   end

`ifdef REGFILE_PARITY_EN
   logic [ADDR_W-1:0] first_a;
   logic              clr_go;

   assign clr_go = clr_req & ~busy;

   always_comb begin
      first_a = '0;
      for (int p = NUM_RD - 1; p >= 0; p--)
         if (perr_p[p]) first_a = rd_addr[p*ADDR_W +: ADDR_W];
   end

   always_ff @(posedge clk) begin
      if (rst || clr_go) begin
         par_err      <= 1'b0;
         par_err_addr <= '0;
      end else if (!par_err && |perr_p) begin
         par_err      <= 1'b1;
         par_err_addr <= first_a;
      end
   end
`else
   assign par_err      = 1'b0;
   assign par_err_addr = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int DEP = 32;
   localparam int AW  = 5;
   localparam int NR  = 2;
   localparam int NW  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             clr_req;
   logic             busy;
   logic [NW-1:0]    wr_en;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_data;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic             wr_conflict;
   logic             par_err;
   logic [AW-1:0]    par_err_addr;

   regfile_mp dut (
      .clk          (clk),
      .rst          (rst),
      .clr_req      (clr_req),
      .busy         (busy),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .wr_conflict  (wr_conflict),
      .par_err      (par_err),
      .par_err_addr (par_err_addr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: remaining scrub cycles, array contents, corrupted entries.
   logic [DW-1:0] m_mem [DEP];
   bit            m_bad [DEP];
   int            m_left = DEP;
   bit            m_conf = 1'b0;
   bit            m_perr = 1'b0;
   logic [AW-1:0] m_paddr = '0;
   bit            chk_on = 1'b0;

   function automatic int wa(input int k);
      return int'(wr_addr[k*AW +: AW]);
   endfunction

   function automatic int ra(input int p);
      return int'(rd_addr[p*AW +: AW]);
   endfunction

   function automatic bit bypassed(input int a);
      bit b = 1'b0;
      for (int k = 0; k < NW; k++) if (wr_en[k] && wa(k) == a) b = 1'b1;
      return b;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input int p);
      int a;
      logic [DW-1:0] v;
      a = ra(p);
      if (m_left > 0 || a == 0) return '0;
      v = m_mem[a];
      for (int k = 0; k < NW; k++) if (wr_en[k] && wa(k) == a) v = wr_data[k*DW +: DW];
      return v;
   endfunction

   always @(posedge clk) begin
      chk_on <= 1'b1;
      if (rst) begin
         m_left  <= DEP;
         m_conf  <= 1'b0;
         m_perr  <= 1'b0;
         m_paddr <= '0;
         for (int i = 0; i < DEP; i++) begin m_mem[i] <= '0; m_bad[i] <= 1'b0; end
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         m_conf <= 1'b0;
      end else begin
         m_conf <= wr_en[0] && wr_en[1] && wa(0) == wa(1);
         for (int k = 0; k < NW; k++)
            if (wr_en[k] && wa(k) != 0) begin
               m_mem[wa(k)] <= wr_data[k*DW +: DW];
               m_bad[wa(k)] <= 1'b0;
            end
         if (!m_perr)
            for (int p = NR - 1; p >= 0; p--)
               if (ra(p) != 0 && m_bad[ra(p)] && !bypassed(ra(p))) begin
                  m_perr  <= 1'b1;
                  m_paddr <= AW'(ra(p));
               end
         if (clr_req) begin
            m_left  <= DEP;
            m_perr  <= 1'b0;
            m_paddr <= '0;
            for (int i = 0; i < DEP; i++) begin m_mem[i] <= '0; m_bad[i] <= 1'b0; end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy", 64'(busy), 64'(m_left > 0));
         chk("wr_conflict", 64'(wr_conflict), 64'(m_conf));
         for (int p = 0; p < NR; p++) chk("rd_data", 64'(rd_data[p*DW +: DW]), 64'(exp_rd(p)));
         chk("par_err", 64'(par_err), 64'(m_perr));
         chk("par_err_addr", 64'(par_err_addr), 64'(m_paddr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      clr_req = 1'b0;
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin n++; tick(); end
      chk("idle_timeout", 64'(n < 200), 64'd1);
   endtask

   task automatic read_all_zero(input string nm);
      for (int a = 0; a < DEP; a += 2) begin
         rd_addr = {AW'(a + 1), AW'(a)};
         #1;
         chk(nm, 64'(rd_data[DW-1:0]), 64'd0);
         chk(nm, 64'(rd_data[2*DW-1:DW]), 64'd0);
         tick();
      end
   endtask

`ifdef REGFILE_PARITY_EN
   task automatic corrupt(input int a);
      dut.mem[a][0] = ~dut.mem[a][0];
      m_mem[a] <= m_mem[a] ^ 32'h1;
      m_bad[a] <= 1'b1;
   endtask
`endif

   initial begin
      int n;
      idle_in();
      rd_addr = '0;
      rst     = 1'b1;
      repeat (3) tick();

      // Reset scrub length
      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin n++; tick(); end
      chk("reset_busy_len", 64'(n), 64'd32);
      chk("reset_busy_low", 64'(busy), 64'd0);
      read_all_zero("reset_zero");

      // Bypass
      wr_en = 2'b01; wr_addr[AW-1:0] = 5'd5; wr_data[DW-1:0] = 32'hDEADBEEF;
      rd_addr[AW-1:0] = 5'd5;
      #1 chk("bypass", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
      tick();
      wr_en = '0;
      #1 chk("array_5", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
      tick();

      // Write conflict
      wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22222222, 32'h11111111};
      rd_addr[AW-1:0] = 5'd7;
      #1 chk("conflict_bypass", 64'(rd_data[DW-1:0]), 64'h22222222);
      tick();
      wr_en = '0;
      #1 chk("conflict_flag", 64'(wr_conflict), 64'd1);
      chk("conflict_array", 64'(rd_data[DW-1:0]), 64'h22222222);
      tick();
      #1 chk("conflict_pulse", 64'(wr_conflict), 64'd0);

      // Zero register
      wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data[DW-1:0] = 32'hFFFFFFFF;
      rd_addr = {5'd0, 5'd0};
      #1 chk("zero_same", 64'(rd_data[DW-1:0]), 64'd0);
      tick();
      wr_en = '0;
      #1 chk("zero_next", 64'(rd_data[DW-1:0]), 64'd0);
      tick();

      // Scrub: fill, request, ignored re-request and dropped write while busy
      for (int i = 0; i < DEP / 2; i++) begin
         wr_en   = 2'b11;
         wr_addr = {AW'(2*i + 1), AW'(2*i)};
         wr_data = {$urandom | 32'h1, $urandom | 32'h1};
         tick();
      end
      wr_en = '0;
      rd_addr = {5'd3, 5'd31};
      #1 chk("fill_31", 64'(rd_data[DW-1:0] != 0), 64'd1);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         clr_req = (n == 10);
         if (n == 5) begin
            wr_en = 2'b01; wr_addr[AW-1:0] = 5'd3; wr_data[DW-1:0] = 32'hCAFEF00D;
         end else wr_en = '0;
         tick();
      end
      idle_in();
      chk("scrub_busy_len", 64'(n), 64'd32);
      read_all_zero("scrub_zero");

`ifdef REGFILE_PARITY_EN
      wr_en = 2'b01; wr_addr[AW-1:0] = 5'd9; wr_data[DW-1:0] = 32'hA5A5A5A5;
      tick();
      wr_en = 2'b01; wr_addr[AW-1:0] = 5'd12; wr_data[DW-1:0] = 32'h5A5A5A5A;
      tick();
      wr_en = '0;
      corrupt(9);
      corrupt(12);
      rd_addr = {5'd9, 5'd9};
      tick();
      rd_addr = '0;
      #1 chk("par_err_set", 64'(par_err), 64'd1);
      chk("par_err_addr9", 64'(par_err_addr), 64'd9);
      rd_addr = {5'd12, 5'd12};
      tick();
      rd_addr = '0;
      #1 chk("par_err_keep", 64'(par_err_addr), 64'd9);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      #1 chk("par_err_clr", 64'(par_err), 64'd0);
      chk("par_addr_clr", 64'(par_err_addr), 64'd0);
      wait_idle();
`endif

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         rst     = ($urandom_range(0, 499) == 0);
         clr_req = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < NW; k++) begin
            wr_en[k] = 1'($urandom_range(0, 1));
            wr_addr[k*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3))
                                                       : AW'($urandom_range(0, DEP - 1));
            wr_data[k*DW +: DW] = $urandom;
         end
         for (int p = 0; p < NR; p++)
            rd_addr[p*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3))
                                                       : AW'($urandom_range(0, DEP - 1));
         tick();
      end
      rst = 1'b0;
      idle_in();
      wait_idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the coprocessor core. Successor to the fixed 32x32, 1-write/2-read register file.
- Adds configurable width, depth and port counts, plus same-cycle write-to-read bypass and write-conflict detection.
- Adds a sequential scrub engine that zeroes key/state registers after reset or on software request.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 32, bits per entry.
- DEPTH, 32, number of entries; must be >=2.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- NUM_RD, 2, read ports (1..4).
- NUM_WR, 2, write ports (1..2).
- ZERO_REG, 1, if 1 then entry 0 is hardwired zero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high; clock clk.
- clr_req  in  1  scrub request (single-cycle pulse).
- busy  out  1  scrub in progress.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  flattened; port k at [k*ADDR_W +: ADDR_W].
- wr_data  in  NUM_WR*DATA_W  flattened, same packing as wr_addr.
- rd_addr  in  NUM_RD*ADDR_W  flattened.
- rd_data  out  NUM_RD*DATA_W  flattened, combinational.
- wr_conflict  out  1  registered pulse: two ports wrote the same address.
- par_err  out  1  sticky parity error (see Optional Feature).
- par_err_addr  out  ADDR_W  address of first parity error.

Behaviour:
- Storage array updates on posedge clk only. No writes happen from combinational logic.
- Scrub FSM, states IDLE and CLEAR:
  - rst=1: state<=CLEAR, cnt<=0, wr_conflict<=0, par_err<=0, par_err_addr<=0.
  - CLEAR: each cycle writes 0 to entry cnt and increments cnt. When cnt==DEPTH-1, the write completes and state<=IDLE.
  - After rst deasserts, busy is high for exactly DEPTH cycles, then low.
  - IDLE with clr_req=1: next state CLEAR, cnt=0. The scrub also clears par_err and par_err_addr.
  - clr_req while in CLEAR: ignored; the counter does not restart.
  - rst mid-scrub: restarts at cnt=0.
- busy = (state==CLEAR). Its reset value is 1.
- While busy:
  - All wr_en inputs are dropped (no array update, no conflict flag).
  - All rd_data read 0.
- Writes (IDLE only):
  - Port k writes wr_data[k] to wr_addr[k] when wr_en[k]=1.
  - Same address on both ports: the higher port index wins, and wr_conflict=1 on the following cycle only.
  - wr_conflict is otherwise 0 (reset value 0).
- Reads, combinational, per port, in priority order:
  1. ZERO_REG=1 and addr==0: read 0.
  2. Any enabled write this cycle to the same address: bypass wr_data, highest index wins.
  3. Otherwise: array contents.
- ZERO_REG=1: writes to entry 0 are discarded and never bypassed; the scrub still walks entry 0.
- Reads are fully independent across ports; any port may use any address, including the same address.
- Reset value of rd_data is 0 (busy forces 0).

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed from the written data; scrub writes parity 0.
  - Every array read (not bypass, not zero-reg, not busy) checks parity.
  - On the first mismatch, par_err<=1 (sticky) and par_err_addr captures the address from the lowest-index failing port.
  - Later errors do not overwrite par_err_addr.
  - par_err and par_err_addr are cleared only by rst or by a clr_req scrub.
  - rd_data still returns the stored data; no correction is performed.
- Undefined: no parity storage; par_err and par_err_addr are tied to 0. The port list is identical in both builds.

Decomposition:
- Package regfile_pkg:
  - default constants (DATA_W_DEF, DEPTH_DEF);
  - scrub state typedef (ST_IDLE, ST_CLEAR);
  - parity function.
- Sub-module regfile_scrub_ctrl: FSM, cnt, busy, scrub write strobe/address. The top level muxes the scrub write into the array.

Test Plan:
1. Reset, default params: hold rst 3 cycles, then release -> busy=1 for exactly 32 cycles, 0 on cycle 33; afterwards rd_addr 0..31 all read 0x00000000.
2. Bypass: write port0 addr 5 = 0xDEADBEEF with rd0_addr=5 in the same cycle -> rd0_data=0xDEADBEEF combinationally; array holds the value on the next cycle.
3. Conflict: port0 and port1 both write addr 7 (0x11111111 / 0x22222222) -> same-cycle read gives 0x22222222; wr_conflict=1 for one cycle; array=0x22222222.
4. Zero register: write addr 0 = 0xFFFFFFFF -> read addr 0 = 0 in the same and next cycle; no bypass.
5. Scrub: fill all entries, pulse clr_req, pulse clr_req again at scrub cycle 10, attempt a write at cycle 5 -> busy for 32 cycles (no restart), write dropped, all entries read 0 afterwards.
6. Parity (REGFILE_PARITY_EN): write addr 9 = 0xA5A5A5A5, bench forces one array bit flipped, read addr 9 on two ports -> par_err=1 next cycle, par_err_addr=9; a later flipped addr 12 read leaves par_err_addr=9; clr_req clears both.
